// File: rtl/fetch_issue_queue.sv
// Prefetch FIFO between the instruction port and issue, with static
// next-PC pre-decode, indirect-jump stall and flush handling.
module fetch_issue_queue #(
  parameter int          DEPTH          = 4,
  parameter bit          BRANCH_PREDICT = 1'b1,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_pipline,
  input  logic [31:0]                  reset_PC_to,
  input  logic                         jalr_just_done,
  input  logic [31:0]                  jalr_resulting_PC,
  output logic                         fetch_req,
  output logic [31:0]                  fetch_addr,
  input  logic                         fetch_ack,
  input  logic [31:0]                  fetch_data,
  input  logic                         issue_space_available,
  output logic                         is_issueing,
  output logic [31:0]                  issue_PC,
  output logic [31:0]                  issue_predicted_PC,
  output logic [31:0]                  issue_ins,
  output logic                         issue_is_compressed,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pred;
    logic        comp;
  } entry_t;

  entry_t      q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0] pc;
  logic        waiting_jalr;
  logic        drop;

  logic        comp;
  logic        is_jalr;
  logic [31:0] pred;
  logic [31:0] seq_pc;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] cj_imm;
  logic [31:0] cb_imm;
  logic        c_j;
  logic        c_b;
  logic        c_jr;
  logic        op_jal;
  logic        op_br;
  logic        op_jalr;

  logic        ack_now;
  logic        push;
  logic        issue_now;
  logic        start;

  always_comb begin
    comp    = fetch_data[1:0] != 2'b11;
    seq_pc  = fetch_addr + (comp ? 32'd2 : 32'd4);
    j_imm   = {{12{fetch_data[31]}}, fetch_data[19:12],
               fetch_data[20], fetch_data[30:21], 1'b0};
    b_imm   = {{20{fetch_data[31]}}, fetch_data[7],
               fetch_data[30:25], fetch_data[11:8], 1'b0};
    cj_imm  = {{21{fetch_data[12]}}, fetch_data[8],
               fetch_data[10:9], fetch_data[6], fetch_data[7],
               fetch_data[2], fetch_data[11], fetch_data[5:3], 1'b0};
    cb_imm  = {{24{fetch_data[12]}}, fetch_data[6:5],
               fetch_data[2], fetch_data[11:10],
               fetch_data[4:3], 1'b0};
    c_j     = comp && fetch_data[1:0] == 2'b01 &&
              fetch_data[14:13] == 2'b01;
    c_b     = comp && fetch_data[1:0] == 2'b01 &&
              fetch_data[15:14] == 2'b11;
    c_jr    = comp && fetch_data[1:0] == 2'b10 &&
              fetch_data[15:13] == 3'b100 &&
              fetch_data[6:2] == 5'd0 &&
              fetch_data[11:7] != 5'd0;
    op_jal  = !comp && fetch_data[6:0] == 7'b1101111;
    op_br   = !comp && fetch_data[6:0] == 7'b1100011;
    op_jalr = !comp && fetch_data[6:0] == 7'b1100111;
    pred    = seq_pc;
    is_jalr = 1'b0;
    unique case (1'b1)
      op_jal: pred = fetch_addr + j_imm;
      c_j:    pred = fetch_addr + cj_imm;
      op_br:  if (BRANCH_PREDICT && b_imm[31])
                pred = fetch_addr + b_imm;
      c_b:    if (BRANCH_PREDICT && cb_imm[31])
                pred = fetch_addr + cb_imm;
      op_jalr,
      c_jr:   is_jalr = 1'b1;
      default: pred = seq_pc;
    endcase
  end

  assign ack_now   = fetch_req && fetch_ack;
  assign push      = ack_now && !drop && !flush_pipline;
  assign issue_now = queue_count != '0 && issue_space_available &&
                     !flush_pipline;
  assign start     = !fetch_req && !waiting_jalr && !flush_pipline &&
                     queue_count < CW'(DEPTH);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_req           <= 1'b0;
      fetch_addr          <= '0;
      is_issueing         <= 1'b0;
      issue_PC            <= '0;
      issue_predicted_PC  <= '0;
      issue_ins           <= '0;
      issue_is_compressed <= 1'b0;
      queue_count         <= '0;
      head                <= '0;
      tail                <= '0;
      pc                  <= RESET_PC;
      waiting_jalr        <= 1'b0;
      drop                <= 1'b0;
    end else if (rdy_in) begin
      // a flushed request stays on the bus until acked; drop marks it
      if (ack_now) begin
        fetch_req <= 1'b0;
        drop      <= 1'b0;
      end else if (fetch_req) begin
        if (flush_pipline) drop <= 1'b1;
      end else if (start) begin
        fetch_req  <= 1'b1;
        fetch_addr <= pc;
      end
      if (flush_pipline)
        pc <= reset_PC_to;
      else if (push)
        pc <= pred;
      else if (jalr_just_done && waiting_jalr)
        pc <= jalr_resulting_PC;
      if (flush_pipline)
        waiting_jalr <= 1'b0;
      else if (push && is_jalr)
        waiting_jalr <= 1'b1;
      else if (jalr_just_done)
        waiting_jalr <= 1'b0;
      is_issueing <= issue_now;
      if (issue_now) begin
        issue_PC            <= q[head].pc;
        issue_predicted_PC  <= q[head].pred;
        issue_ins           <= q[head].ins;
        issue_is_compressed <= q[head].comp;
        head                <= head + PW'(1);
      end
      if (flush_pipline) begin
        head        <= '0;
        tail        <= '0;
        queue_count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        queue_count <= queue_count + CW'(push) - CW'(issue_now);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && push)
      q[tail] <= '{pc: fetch_addr, ins: fetch_data,
                   pred: pred, comp: comp};
  end

endmodule

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
- Parametrised successor of the single-slot issue manager.
- Decouples instruction fetch from issue with a DEPTH-entry prefetch FIFO.
- Pre-decodes instruction length and static next-PC prediction, including a configurable conditional-branch predictor.
- Stalls fetch on indirect jumps until resolved; flushes on mispredict. Sits between the memory adaptor's instruction port and the CSU/issue logic.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of 2, >=2).
- BRANCH_PREDICT, 1, 0 = conditional branches predicted not-taken; 1 = backward-taken/forward-not-taken.
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  pause when low; all state frozen
- flush_pipline  in  1  discard all queued/in-flight work
- reset_PC_to  in  32  redirect target on flush
- jalr_just_done  in  1  indirect jump resolved this cycle
- jalr_resulting_PC  in  32  resolved indirect target
- fetch_req  out  1  fetch request, held until fetch_ack
- fetch_addr  out  32  address of the outstanding fetch
- fetch_ack  in  1  fetch_data valid for the outstanding request
- fetch_data  in  32  fetched instruction word
- issue_space_available  in  1  downstream can accept an instruction this cycle
- is_issueing  out  1  registered; an instruction is presented this cycle
- issue_PC  out  32  PC of the issued instruction
- issue_predicted_PC  out  32  predicted next PC
- issue_ins  out  32  raw instruction word
- issue_is_compressed  out  1  16-bit instruction
- queue_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async): all outputs 0; fetch PC = RESET_PC; queue empty; pointers 0; waiting_jalr = 0; drop flag = 0.
- rdy_in low: no state or output changes. fetch_ack is ignored.
- Fetch handshake:
  - At most one outstanding request.
  - A request starts only when waiting_jalr = 0 and queue_count + outstanding < DEPTH.
  - fetch_req and fetch_addr stay stable until fetch_ack.
  - The next request may start the cycle after the ack.
- Pre-decode on ack, one entry pushed {pc, word, predicted, compressed}:
  - word[1:0] != 2'b11 means compressed.
  - JAL: pc + J-imm.
  - c.j/c.jal (op 01, funct3 101/001): pc + CJ-imm.
  - BRANCH (1100011): if BRANCH_PREDICT = 1 and imm < 0, pc + B-imm; otherwise pc + 4.
  - c.beqz/c.bnez: same rule, using CB-imm and pc + 2.
  - JALR, c.jr, c.jalr (op 10, funct3 100, rs2 = 0, rs1 != 0): predicted = pc + len; waiting_jalr set.
  - All others: pc + 4 (32-bit) or pc + 2 (compressed).
  - Fetch PC becomes the predicted PC.
  - All address arithmetic is mod 2^32.
- Indirect stall:
  - While waiting_jalr = 1, no new fetch request.
  - jalr_just_done while waiting: fetch PC = jalr_resulting_PC; waiting cleared.
  - jalr_just_done while not waiting: ignored.
- Issue (registered):
  - Each active cycle, is_issueing <= (count != 0) && issue_space_available && !flush_pipline.
  - When set, the head entry is popped into the issue_* registers.
  - Otherwise is_issueing = 0 and issue_* hold.
  - Latency: an entry acked at edge N issues at the earliest at edge N+1. No bypass.
  - Order is strictly FIFO.
- Queue boundaries:
  - Push and pop in the same cycle: count unchanged.
  - Push into a full queue cannot occur (guaranteed by the fetch start condition).
  - Pointers wrap mod DEPTH.
- Flush (highest priority):
  - Clears queue, count, is_issueing and waiting_jalr; fetch PC = reset_PC_to.
  - If a request is outstanding (including an ack in the flush cycle), its data is dropped: no push.
  - The request is still held until its ack, then the drop flag clears and fetching resumes at reset_PC_to.
  - Flush with jalr_just_done in the same cycle: flush wins.

Test Plan:
- RESET_PC = 0; ack 0x00500093 at 0x0 -> next fetch_addr 0x4; one cycle later is_issueing = 1, issue_PC 0x0, issue_predicted_PC 0x4, compressed 0.
- Ack 0x0100006F (jal x0,16) at 0x10 -> predicted 0x20, next fetch_addr 0x20. Ack 0x0001 (c.nop) at 0x100 -> predicted 0x102, compressed 1.
- Ack 0xFE000CE3 (beq x0,x0,-8) at 0x40 -> BRANCH_PREDICT = 1: predicted/next fetch 0x38; BRANCH_PREDICT = 0: 0x44.
- Ack 0x00008067 (ret) at 0x80 -> fetch_req stays 0 for 10 cycles; jalr_just_done with 0x200 -> fetch_addr 0x200.
- issue_space_available = 0, DEPTH = 4 acks -> queue_count 4, fetch_req 0. Release -> 4 consecutive issues in PC order, count returns to 0.
- Flush (reset_PC_to 0x300) in the same cycle as an ack -> queue_count 0, is_issueing 0, no push; next fetch_addr 0x300. Assert rst_in mid-fetch -> outputs 0 immediately, without a clock edge.
